// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: opcode encoding, flag bit
// positions and a helper that packs the four status bits.
package alu_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SUB   = 3'd3,
    NEG   = 3'd4,
    NOT   = 3'd5,
    AND   = 3'd6,
    XOR   = 3'd7
  } opcode_e;

  localparam int FLAG_N    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;
  localparam int NUM_FLAGS = 4;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit adder with carry-in; reports carry-out and two's-complement
// overflow so ADD, SUB and NEG can all share it.
module alu_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH:0] full;

  assign full    = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_i};
  assign sum_o   = full[WIDTH-1:0];
  assign carry_o = full[WIDTH];

  // Overflow: both addends share a sign that the sum does not.
  assign overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                      (full[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Single-accumulator ALU: applies one opcode per clock to the accumulator
// and the operand, registering the result and the N/Z/C/V flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] accumulator,
  output logic [3:0]       flags
);

  opcode_e op;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;

  logic [WIDTH-1:0] addA;
  logic [WIDTH-1:0] addB;
  logic             addCin;
  logic [WIDTH-1:0] addSum;
  logic             addCout;
  logic             addOvf;

  assign op = opcode_e'(control);

  // ADD, SUB and NEG reuse one adder: (acc,in,0), (acc,~in,1), (0,~acc,1).
  always_comb begin
    addA   = acc_q;
    addB   = in;
    addCin = 1'b0;
    case (op)
      SUB: begin
        addB   = ~in;
        addCin = 1'b1;
      end
      NEG: begin
        addA   = '0;
        addB   = ~acc_q;
        addCin = 1'b1;
      end
      default: ;
    endcase
  end

  alu_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i       (addA),
    .b_i       (addB),
    .carry_i   (addCin),
    .sum_o     (addSum),
    .carry_o   (addCout),
    .overflow_o(addOvf)
  );

  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    case (op)
      HOLD: ;
      CLEAR: begin
        acc_d   = '0;
        flags_d = pack_flags(1'b0, 1'b1, 1'b0, 1'b0);
      end
      ADD, SUB, NEG: begin
        acc_d   = addSum;
        flags_d = pack_flags(addSum[WIDTH-1], addSum == '0, addCout, addOvf);
      end
      NOT: begin
        acc_d   = ~acc_q;
        flags_d = pack_flags(acc_d[WIDTH-1], acc_d == '0, 1'b0, 1'b0);
      end
      AND: begin
        acc_d   = acc_q & in;
        flags_d = pack_flags(acc_d[WIDTH-1], acc_d == '0, 1'b0, 1'b0);
      end
      XOR: begin
        acc_d   = acc_q ^ in;
        flags_d = pack_flags(acc_d[WIDTH-1], acc_d == '0, 1'b0, 1'b0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign accumulator = acc_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard-driven bench for the accumulator ALU: directed scenarios with
// hand-derived results followed by a randomised run against a behavioural model.
module tb_alu;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] acc;
    logic [3:0] flags;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [2:0] ctrl;
    logic [7:0] operand;
    logic [7:0] acc;
    logic [3:0] flags;
  } step_t;

  logic       clk;
  logic       rst;
  logic [7:0] operand;
  logic [2:0] control;
  logic [7:0] accumulator;
  logic [3:0] flags;

  exp_t sb[$];
  int   assertCount;
  int   failCount;

  alu #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (operand),
    .control    (control),
    .accumulator(accumulator),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, record its expected outcome, then move to 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic [2:0] c, input logic [7:0] x,
                               input logic [7:0] eAcc, input logic [3:0] eFlags);
    exp_t e;
    rst     = r;
    control = c;
    operand = x;
    e.acc   = eAcc;
    e.flags = eFlags;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Independent reference: unsigned/signed integer arithmetic decides C and V.
  function automatic exp_t modelStep(input logic r, input logic [2:0] op,
                                     input logic [7:0] x, input exp_t cur);
    exp_t nx;
    int   ua, ux, sa, sx, u, s;
    logic c, v;
    nx = cur;
    ua = int'(cur.acc);
    ux = int'(x);
    sa = $signed(cur.acc);
    sx = $signed(x);
    c  = 1'b0;
    v  = 1'b0;
    if (r) begin
      nx.acc   = 8'h00;
      nx.flags = 4'b0000;
      return nx;
    end
    case (op)
      3'd0: return nx;
      3'd1: nx.acc = 8'h00;
      3'd2: begin
        u = ua + ux;
        s = sa + sx;
        nx.acc = u[7:0];
        c = (u > 255);
        v = (s > 127) || (s < -128);
      end
      3'd3: begin
        u = ua - ux;
        s = sa - sx;
        nx.acc = u[7:0];
        c = (ua >= ux);
        v = (s > 127) || (s < -128);
      end
      3'd4: begin
        u = 0 - ua;
        s = 0 - sa;
        nx.acc = u[7:0];
        c = (ua == 0);
        v = (s > 127);
      end
      3'd5: nx.acc = ~cur.acc;
      3'd6: nx.acc = cur.acc & x;
      default: nx.acc = cur.acc ^ x;
    endcase
    nx.flags = {nx.acc[7], nx.acc == 8'h00, c, v};
    return nx;
  endfunction

  task automatic test_reset();
    step_t steps[2];
    exp_t  e;
    steps = '{'{1'b1, 3'd2, 8'h33, 8'h00, 4'b0000},
              '{1'b0, 3'd0, 8'h77, 8'h00, 4'b0000}};
    foreach (steps[i]) begin
      applyStimulus(steps[i].rst, steps[i].ctrl, steps[i].operand, steps[i].acc, steps[i].flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL reset[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL reset[%0d]: got %h/%b, expected %h/%b", i, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  task automatic test_basic_arith();
    step_t steps[4];
    exp_t  e;
    steps = '{'{1'b0, 3'd2, 8'h05, 8'h05, 4'b0000},
              '{1'b0, 3'd0, 8'hAA, 8'h05, 4'b0000},
              '{1'b0, 3'd3, 8'h03, 8'h02, 4'b0010},
              '{1'b0, 3'd4, 8'h55, 8'hFE, 4'b1000}};
    foreach (steps[i]) begin
      applyStimulus(steps[i].rst, steps[i].ctrl, steps[i].operand, steps[i].acc, steps[i].flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL arith[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL arith[%0d]: got %h/%b, expected %h/%b", i, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  task automatic test_clear_logic();
    step_t steps[4];
    exp_t  e;
    steps = '{'{1'b0, 3'd1, 8'hFF, 8'h00, 4'b0100},
              '{1'b0, 3'd5, 8'h3C, 8'hFF, 4'b1000},
              '{1'b0, 3'd7, 8'h09, 8'hF6, 4'b1000},
              '{1'b0, 3'd6, 8'h0C, 8'h04, 4'b0000}};
    foreach (steps[i]) begin
      applyStimulus(steps[i].rst, steps[i].ctrl, steps[i].operand, steps[i].acc, steps[i].flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL logic[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL logic[%0d]: got %h/%b, expected %h/%b", i, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  task automatic test_overflow();
    step_t steps[7];
    exp_t  e;
    steps = '{'{1'b0, 3'd1, 8'h00, 8'h00, 4'b0100},
              '{1'b0, 3'd2, 8'h78, 8'h78, 4'b0000},
              '{1'b0, 3'd2, 8'h39, 8'hB1, 4'b1001},
              '{1'b0, 3'd1, 8'h00, 8'h00, 4'b0100},
              '{1'b0, 3'd2, 8'h88, 8'h88, 4'b1000},
              '{1'b0, 3'd2, 8'hC7, 8'h4F, 4'b0011},
              '{1'b0, 3'd0, 8'h12, 8'h4F, 4'b0011}};
    foreach (steps[i]) begin
      applyStimulus(steps[i].rst, steps[i].ctrl, steps[i].operand, steps[i].acc, steps[i].flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL overflow[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL overflow[%0d]: got %h/%b, expected %h/%b", i, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  // Starts from acc=4F left by the overflow scenario.
  task automatic test_reset_mid();
    step_t steps[2];
    exp_t  e;
    steps = '{'{1'b1, 3'd2, 8'h01, 8'h00, 4'b0000},
              '{1'b0, 3'd2, 8'h01, 8'h01, 4'b0000}};
    foreach (steps[i]) begin
      applyStimulus(steps[i].rst, steps[i].ctrl, steps[i].operand, steps[i].acc, steps[i].flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL reset_mid[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL reset_mid[%0d]: got %h/%b, expected %h/%b", i, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  task automatic test_edge_cases();
    step_t steps[10];
    exp_t  e;
    steps = '{'{1'b0, 3'd1, 8'h00, 8'h00, 4'b0100},
              '{1'b0, 3'd2, 8'h80, 8'h80, 4'b1000},
              '{1'b0, 3'd4, 8'h00, 8'h80, 4'b1001},
              '{1'b0, 3'd1, 8'h00, 8'h00, 4'b0100},
              '{1'b0, 3'd4, 8'hFF, 8'h00, 4'b0110},
              '{1'b0, 3'd2, 8'h05, 8'h05, 4'b0000},
              '{1'b0, 3'd3, 8'h05, 8'h00, 4'b0110},
              '{1'b0, 3'd1, 8'h00, 8'h00, 4'b0100},
              '{1'b0, 3'd2, 8'h03, 8'h03, 4'b0000},
              '{1'b0, 3'd3, 8'h05, 8'hFE, 4'b1000}};
    foreach (steps[i]) begin
      applyStimulus(steps[i].rst, steps[i].ctrl, steps[i].operand, steps[i].acc, steps[i].flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL edge[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL edge[%0d]: got %h/%b, expected %h/%b", i, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  // Back-to-back random opcodes every cycle, tracked by the reference model.
  task automatic test_back_to_back();
    exp_t       model;
    exp_t       e;
    logic       r;
    logic [2:0] c;
    logic [7:0] x;
    model.acc   = 8'h00;
    model.flags = 4'b0000;
    applyStimulus(1'b1, 3'd0, 8'h00, model.acc, model.flags);
    void'(sb.pop_front());
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      c = 3'($urandom_range(0, 7));
      x = (($urandom_range(0, 3) == 0)) ? 8'($urandom_range(0, 1) * 8'h80) : 8'($urandom_range(0, 255));
      model = modelStep(r, c, x, model);
      applyStimulus(r, c, x, model.acc, model.flags);
      assertCount++;
      if (sb.size() == 0) begin
        failCount++;
        $display("[TB] FAIL random[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if (accumulator !== e.acc || flags !== e.flags) begin
          failCount++;
          $display("[TB] FAIL random[%0d] op=%0d in=%h rst=%b: got %h/%b, expected %h/%b",
                   i, c, x, r, accumulator, flags, e.acc, e.flags);
        end
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    control     = 3'd0;
    operand     = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_arith();
    test_clear_logic();
    test_overflow();
    test_reset_mid();
    test_edge_cases();
    test_back_to_back();
    assertCount++;
    if (sb.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Single-accumulator ALU. Each clock edge applies an operation selected by a 3-bit opcode to the internal accumulator and the input operand.
- Result and status flags are registered.
- Serves as the datapath core of a simple accumulator-style processor.
- The accumulator value and the flags are visible on the outputs at all times.

Parameters:
- WIDTH, 8, data width of the operand input and the accumulator (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  operand, two's complement.
- control  input  3  opcode.
- accumulator  output  WIDTH  registered accumulator value.
- flags  output  4  registered status: [3]=N, [2]=Z, [1]=C, [0]=V.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, accumulator<=0 and flags<=4'b0000. Reset overrides control.
- Latency: an operation presented before edge k is visible on the outputs right after edge k. There is no handshake, and a new opcode is accepted every cycle.
- Opcodes:
  - 0 HOLD: accumulator and flags both unchanged.
  - 1 CLEAR: acc<=0; flags<=0100 (Z=1).
  - 2 ADD: acc<=acc+in, mod 2^WIDTH.
  - 3 SUB: acc<=acc-in, computed as acc+~in+1.
  - 4 NEG: acc<=0-acc, computed as ~acc+1.
  - 5 NOT: acc<=~acc.
  - 6 AND: acc<=acc&in.
  - 7 XOR: acc<=acc^in.
- N = MSB of result. Z = (result==0). Both apply to every opcode except HOLD.
- C is the carry-out of the WIDTH-bit adder:
  - ADD: carry of acc+in.
  - SUB: carry of acc+~in+1, so 1 means no borrow.
  - NEG: carry of ~acc+1, which is 1 only when acc==0.
- V is signed overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from acc.
  - NEG: 1 only when acc is the most-negative value (10..0); the result is then 10..0.
- Logic ops (NOT/AND/XOR) and CLEAR force C=0 and V=0.
- Wrap-around is silent, reported only through C and V. The accumulator is never saturated.
- `in` is ignored for HOLD, CLEAR, NEG and NOT.
- Flags always describe the most recent non-HOLD result, or reset.

Decomposition:
- Shared package alu_pkg:
  - opcode constants HOLD, CLEAR, ADD, SUB, NEG, NOT, AND, XOR (3-bit localparams/enum);
  - flag bit-index constants FLAG_N, FLAG_Z, FLAG_C, FLAG_V.
- One natural sub-module, alu_adder: a WIDTH-bit adder with carry-in, returning sum, carry-out and overflow.
  - It is shared by ADD, SUB and NEG through operand muxing: ADD = (acc, in, 0), SUB = (acc, ~in, 1), NEG = (0, ~acc, 1).
- The top level holds the opcode mux, flag logic and the registers.

Test Plan (WIDTH=8; each step is one clock; values given after the edge):
- Reset then basic arithmetic: rst=1 -> acc=00, flags=0000. Then ADD 5 -> 05/0000. HOLD -> 05/0000. SUB 3 -> 02/0010. NEG -> FE/1000.
- CLEAR and logic: CLEAR -> 00/0100. NOT -> FF/1000. XOR 9 -> F6/1000. AND 12 -> 04/0000.
- Positive overflow: CLEAR, ADD 120 -> 78/0000. ADD 57 -> B1/1001 (N,V).
- Negative overflow: CLEAR, ADD -120 (88) -> 88/1000. ADD -57 (C7) -> 4F/0011 (C,V).
- Edge cases:
  - acc=80, NEG -> 80/1001.
  - acc=00, NEG -> 00/0110.
  - acc=05, SUB 5 -> 00/0110.
  - acc=03, SUB 5 -> FE/1000.
- Reset mid-operation: with acc=4F and rst=1 while control=ADD 1 -> 00/0000. Then rst=0, ADD 1 -> 01/0000.
